// File: rtl/cla_pkg.sv
// Shared constants and elaboration helpers for the pipelined CLA adder/subtractor.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // Returns the stage count, or 0 for an illegal WIDTH/GROUP pairing.
  function automatic int cla_stages(input int width, input int group);
    if (group < 1 || width < group || (width % group) != 0) begin
      return 0;
    end
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice: full lookahead, no internal ripple.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;
  logic             prop;

  // c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin, each term formed directly.
  always_comb begin
    p    = a ^ b;
    g    = a & b;
    c    = '0;
    prop = 1'b0;
    c[0] = cin;
    for (int i = 0; i < GROUP; i++) begin
      c[i+1] = g[i];
      prop   = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (prop & g[j]);
        prop   = prop & p[j];
      end
      c[i+1] = c[i+1] | (prop & cin);
    end
  end

  assign sum  = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];
  assign cmsb = c[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined CLA adder/subtractor: one lookahead group resolved per stage, stream handshake.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = cla_stages(WIDTH, GROUP);

  if (STAGES < 1) begin : g_bad_cfg
    $error("cla_addsub_pipe: WIDTH must be a multiple of GROUP and >= GROUP");
  end

  logic                    adv;
  logic                    sub_eff;

  logic [STAGES-1:0]       vld_q, vld_d;
  logic [STAGES-1:0]       c_q, c_d;
  logic [WIDTH-1:0]        a_q   [STAGES];
  logic [WIDTH-1:0]        b_q   [STAGES];
  logic [WIDTH-1:0]        sum_q [STAGES];
  logic [WIDTH-1:0]        a_d   [STAGES];
  logic [WIDTH-1:0]        b_d   [STAGES];
  logic [WIDTH-1:0]        sum_s [STAGES];
  logic [WIDTH-1:0]        sum_d [STAGES];
  logic [STAGES-1:0]       cin_s;
  logic                    ovf_q, ovf_d;
  logic                    zero_q, zero_d;

  logic [STAGES-1:0][GROUP-1:0] gsum;
  logic [STAGES-1:0]            gcout;
  logic                         cmsb_top;

  assign adv     = out_ready | ~out_valid;
  assign sub_eff = (in_sub == MODE_SUB);

  // Stage inputs: stage 0 takes the operand beat (B inverted for subtract), later stages the previous register.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      if (k == 0) begin
        a_d[k]   = in_a;
        b_d[k]   = in_b ^ {WIDTH{sub_eff}};
        cin_s[k] = in_cin ^ sub_eff;
        sum_s[k] = '0;
        vld_d[k] = in_valid;
      end else begin
        a_d[k]   = a_q[k-1];
        b_d[k]   = b_q[k-1];
        cin_s[k] = c_q[k-1];
        sum_s[k] = sum_q[k-1];
        vld_d[k] = vld_q[k-1];
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == STAGES - 1) begin : g_top
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (a_d[k][k*GROUP +: GROUP]),
        .b    (b_d[k][k*GROUP +: GROUP]),
        .cin  (cin_s[k]),
        .sum  (gsum[k]),
        .cout (gcout[k]),
        .cmsb (cmsb_top)
      );
    end else begin : g_low
      logic cmsb_unused;
      cla_group #(.GROUP(GROUP)) u_grp (
        .a    (a_d[k][k*GROUP +: GROUP]),
        .b    (b_d[k][k*GROUP +: GROUP]),
        .cin  (cin_s[k]),
        .sum  (gsum[k]),
        .cout (gcout[k]),
        .cmsb (cmsb_unused)
      );
    end
  end

  // Merge each freshly resolved group into the forwarded partial sum; flags come from the last stage.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      sum_d[k]                   = sum_s[k];
      sum_d[k][k*GROUP +: GROUP] = gsum[k];
    end
    c_d    = gcout;
    ovf_d  = gcout[STAGES-1] ^ cmsb_top;
    zero_d = (sum_d[STAGES-1] == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      c_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= '0;
        b_q[k]   <= '0;
        sum_q[k] <= '0;
      end
    end else if (adv) begin
      vld_q  <= vld_d;
      c_q    <= c_d;
      ovf_q  <= ovf_d;
      zero_q <= zero_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k]   <= a_d[k];
        b_q[k]   <= b_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign in_ready  = adv;
  assign out_valid = vld_q[STAGES-1];
  assign out_sum   = sum_q[STAGES-1];
  assign out_cout  = c_q[STAGES-1];
  assign out_ovf   = ovf_q;
  assign out_zero  = zero_q;

endmodule
